stream_hblur: RTL and testbench

//  Avalon-ST video pre-filter placed directly upstream of the colour-detect/bounding-box stage.

---
 rtl/stream_hblur_pkg.sv | 33 +++
 rtl/stream_hblur_tap3.sv | 15 +
 rtl/stream_hblur.sv | 212 +++++++++++++++++++++
 tb/tb_stream_hblur.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_hblur_pkg.sv
// Shared types and the per-channel 3-tap kernel for the stream_hblur video pre-filter.
package stream_hblur_pkg;

   localparam int unsigned CH_W  = 8;
   localparam int unsigned PIX_W = 3 * CH_W;
   localparam int unsigned ACC_W = 10;

   localparam logic [3:0] VIDEO_PKT_ID = 4'h0;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } pixel_t;

   typedef enum logic [2:0] {
      IDLE,
      PASS,
      V_FIRST,
      V_RUN,
      FLUSH
   } state_e;

   // (a + 2b + c + 2) >> 2; the 10-bit sum cannot overflow (max 1022)
   function automatic logic [CH_W-1:0] filt3(input logic [CH_W-1:0] a,
                                            input logic [CH_W-1:0] b,
                                            input logic [CH_W-1:0] c);
      logic [ACC_W-1:0] sum;
      sum = ACC_W'(a) + (ACC_W'(b) << 1) + ACC_W'(c) + ACC_W'(2);
      return sum[ACC_W-1:2];
   endfunction

endpackage

// File: rtl/stream_hblur_tap3.sv
// Combinational [1 2 1]/4 smoothing of three neighbouring pixels, applied per RGB channel.
module hblur_tap3
   import stream_hblur_pkg::*;
(
   input  pixel_t i_a,
   input  pixel_t i_b,
   input  pixel_t i_c,
   output pixel_t o_y
);

   assign o_y.r = filt3(i_a.r, i_b.r, i_c.r);
   assign o_y.g = filt3(i_a.g, i_b.g, i_c.g);
   assign o_y.b = filt3(i_a.b, i_b.b, i_c.b);

endmodule

// File: rtl/stream_hblur.sv
// Avalon-ST horizontal 3-tap blur with edge replication; non-video packets pass unmodified.
// Optional STREAM_HBLUR_FRAMECHK_EN adds frame_err, flagging video packets of the wrong length.
module stream_hblur
   import stream_hblur_pkg::*;
#(
   parameter int unsigned IMAGE_W = 640,
   parameter int unsigned IMAGE_H = 480
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [PIX_W-1:0] sink_data,
   input  logic             sink_valid,
   output logic             sink_ready,
   input  logic             sink_sop,
   input  logic             sink_eop,
   output logic [PIX_W-1:0] source_data,
   output logic             source_valid,
   input  logic             source_ready,
   output logic             source_sop,
   output logic             source_eop,
   input  logic             mode
`ifdef STREAM_HBLUR_FRAMECHK_EN
   ,
   output logic             frame_err
`endif
);

   localparam int unsigned X_W       = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(IMAGE_W - 1);
   localparam int unsigned FRAME_PIX = IMAGE_W * IMAGE_H;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [X_W-1:0]   r_x;
   logic [X_W-1:0]   w_x_nxt;
   logic [X_W-1:0]   w_x_inc;
   pixel_t           r_prev;
   pixel_t           r_cur;
   pixel_t           w_prev_nxt;
   pixel_t           w_cur_nxt;
   logic             r_eop_line;
   logic             w_eop_line_nxt;

   logic [PIX_W-1:0] r_src_data;
   logic             r_src_valid;
   logic             r_src_sop;
   logic             r_src_eop;

   logic             w_out_free;
   logic             w_accept;
   logic             w_line_end;
   logic             w_is_video;
   pixel_t           w_pix;
   pixel_t           w_tap_c;
   pixel_t           w_filt;
   logic             w_out_ld;
   logic [PIX_W-1:0] w_out_data;
   logic             w_out_sop;
   logic             w_out_eop;

   assign w_out_free = ~r_src_valid | source_ready;
   assign sink_ready = w_out_free & (r_state != FLUSH);
   assign w_accept   = sink_valid & sink_ready;
   assign w_pix      = pixel_t'(sink_data);
   assign w_x_inc    = (r_x == X_LAST) ? '0 : r_x + X_W'(1);
   assign w_line_end = (r_x == X_LAST) | sink_eop;
   assign w_is_video = (sink_data[3:0] == VIDEO_PKT_ID);
   // Right edge replicates the last held pixel instead of a new input
   assign w_tap_c    = (r_state == FLUSH) ? r_cur : w_pix;

   hblur_tap3 u_tap (
      .i_a (r_prev),
      .i_b (r_cur),
      .i_c (w_tap_c),
      .o_y (w_filt)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_x_nxt        = r_x;
      w_prev_nxt     = r_prev;
      w_cur_nxt      = r_cur;
      w_eop_line_nxt = r_eop_line;
      w_out_ld       = 1'b0;
      w_out_data     = sink_data;
      w_out_sop      = 1'b0;
      w_out_eop      = 1'b0;

      if (w_accept && sink_sop) begin
         // A descriptor restarts the packet from any state, dropping held pixels
         w_out_ld    = 1'b1;
         w_out_sop   = 1'b1;
         w_out_eop   = sink_eop;
         w_x_nxt     = '0;
         if (sink_eop)
            w_state_nxt = IDLE;
         else
            w_state_nxt = (w_is_video && mode) ? V_FIRST : PASS;
      end else begin
         case (r_state)
            PASS: begin
               if (w_accept) begin
                  w_out_ld  = 1'b1;
                  w_out_eop = sink_eop;
                  if (sink_eop)
                     w_state_nxt = IDLE;
               end
            end
            V_FIRST: begin
               if (w_accept) begin
                  w_prev_nxt     = w_pix;
                  w_cur_nxt      = w_pix;
                  w_x_nxt        = w_x_inc;
                  w_eop_line_nxt = sink_eop;
                  w_state_nxt    = w_line_end ? FLUSH : V_RUN;
               end
            end
            V_RUN: begin
               if (w_accept) begin
                  w_out_ld       = 1'b1;
                  w_out_data     = w_filt;
                  w_prev_nxt     = r_cur;
                  w_cur_nxt      = w_pix;
                  w_x_nxt        = w_x_inc;
                  w_eop_line_nxt = sink_eop;
                  w_state_nxt    = w_line_end ? FLUSH : V_RUN;
               end
            end
            FLUSH: begin
               if (w_out_free) begin
                  w_out_ld    = 1'b1;
                  w_out_data  = w_filt;
                  w_out_eop   = r_eop_line;
                  w_state_nxt = r_eop_line ? IDLE : V_FIRST;
               end
            end
            default: begin
               // IDLE: stray non-SOP words are accepted and dropped
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_prev      <= '0;
         r_cur       <= '0;
         r_eop_line  <= 1'b0;
         r_src_valid <= 1'b0;
         r_src_data  <= '0;
         r_src_sop   <= 1'b0;
         r_src_eop   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_x        <= w_x_nxt;
         r_prev     <= w_prev_nxt;
         r_cur      <= w_cur_nxt;
         r_eop_line <= w_eop_line_nxt;
         if (w_out_ld) begin
            r_src_valid <= 1'b1;
            r_src_data  <= w_out_data;
            r_src_sop   <= w_out_sop;
            r_src_eop   <= w_out_eop;
         end else if (source_ready) begin
            r_src_valid <= 1'b0;
         end
      end
   end

   assign source_data  = r_src_data;
   assign source_valid = r_src_valid;
   assign source_sop   = r_src_sop;
   assign source_eop   = r_src_eop;

`ifdef STREAM_HBLUR_FRAMECHK_EN
   localparam int unsigned CNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX + 1) : 1;

   logic [CNT_W-1:0] r_pix_cnt;
   logic             r_frame_err;
   logic             w_in_video;

   assign w_in_video = (r_state == V_FIRST) || (r_state == V_RUN);

   // Counts pixels of a filtered video packet; pulses on a bad length or an abort
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_cnt   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (w_accept) begin
            if (sink_sop) begin
               r_pix_cnt   <= '0;
               r_frame_err <= w_in_video;
            end else if (w_in_video) begin
               r_pix_cnt <= r_pix_cnt + CNT_W'(1);
               if (sink_eop)
                  r_frame_err <= ((r_pix_cnt + CNT_W'(1)) != CNT_W'(FRAME_PIX));
            end
         end
      end
   end

   assign frame_err = r_frame_err;
`else
   logic w_unused_frame;
   assign w_unused_frame = ^FRAME_PIX;
`endif

endmodule

// File: tb/tb_stream_hblur.sv
// Scoreboard bench for stream_hblur (IMAGE_W=5, IMAGE_H=2); frame_err checked when STREAM_HBLUR_FRAMECHK_EN is set.
module tb_stream_hblur;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [23:0] sink_data;
   logic        sink_valid;
   logic        sink_ready;
   logic        sink_sop;
   logic        sink_eop;
   logic [23:0] source_data;
   logic        source_valid;
   logic        source_ready;
   logic        source_sop;
   logic        source_eop;
   logic        mode;
`ifdef STREAM_HBLUR_FRAMECHK_EN
   logic        frame_err;
`endif

   int          tests = 0;
   int          fails = 0;
   int          fe_count = 0;
   bit          rand_ready = 1'b0;
   logic [25:0] exp_q[$];
   logic [23:0] px [16];

   always #5 clk = ~clk;

   stream_hblur #(.IMAGE_W(5), .IMAGE_H(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sink_data    (sink_data),
      .sink_valid   (sink_valid),
      .sink_ready   (sink_ready),
      .sink_sop     (sink_sop),
      .sink_eop     (sink_eop),
      .source_data  (source_data),
      .source_valid (source_valid),
      .source_ready (source_ready),
      .source_sop   (source_sop),
      .source_eop   (source_eop),
      .mode         (mode)
`ifdef STREAM_HBLUR_FRAMECHK_EN
      ,
      .frame_err    (frame_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Independent reference: per-channel (a + 2b + c + 2) / 4
   function automatic logic [23:0] mfilt(input logic [23:0] a, input logic [23:0] b,
                                         input logic [23:0] c);
      logic [23:0] y;
      int          s;
      for (int k = 0; k < 3; k++) begin
         s = (int'(a[8*k +: 8]) + 2 * int'(b[8*k +: 8]) + int'(c[8*k +: 8]) + 2) / 4;
         y[8*k +: 8] = 8'(s);
      end
      return y;
   endfunction

   // One cycle: sample handshakes at negedge, score any emitted word, advance past posedge
   task automatic tick(output bit acc);
      logic [25:0] exp;
      @(negedge clk);
      acc = sink_valid && sink_ready;
`ifdef STREAM_HBLUR_FRAMECHK_EN
      if (frame_err === 1'b1) fe_count++;
`endif
      if (source_valid && source_ready) begin
         tests++;
         assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL spurious_output observed=%h expected=none",
                   {source_sop, source_eop, source_data});
         end
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("output_word", 32'({source_sop, source_eop, source_data}), 32'(exp));
         end
      end
      @(posedge clk);
      #1;
      if (rand_ready) source_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_word(input logic [23:0] d, input bit sop, input bit eop);
      bit acc = 1'b0;
      sink_data  = d;
      sink_sop   = sop;
      sink_eop   = eop;
      sink_valid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) tick(acc);
      check("accept_in_budget", 32'(acc), 32'd1);
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      for (int n = 0; n < 400 && exp_q.size() > 0; n++) tick(acc);
      for (int n = 0; n < 4; n++) tick(acc);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic send_sop(input logic [23:0] d);
      exp_q.push_back({1'b1, 1'b0, d});
      send_word(d, 1'b1, 1'b0);
   endtask

   // Random video line of n pixels with modelled edge replication
   task automatic send_video_line(input int n, input bit eop_last);
      for (int i = 0; i < n; i++) px[i] = 24'($urandom());
      for (int i = 0; i < n; i++)
         exp_q.push_back({1'b0, eop_last && (i == n - 1),
                          mfilt(px[(i > 0) ? i - 1 : 0], px[i], px[(i < n - 1) ? i + 1 : n - 1])});
      for (int i = 0; i < n; i++) send_word(px[i], 1'b0, eop_last && (i == n - 1));
   endtask

   task automatic test_ramp();
      send_sop(24'h000000);
      exp_q.push_back({2'b00, 24'h0A0000});
      exp_q.push_back({2'b00, 24'h280000});
      exp_q.push_back({2'b00, 24'h500000});
      exp_q.push_back({2'b01, 24'h6E0000});
      send_word(24'h000000, 1'b0, 1'b0);
      send_word(24'h280000, 1'b0, 1'b0);
      send_word(24'h500000, 1'b0, 1'b0);
      send_word(24'h780000, 1'b0, 1'b1);
      drain();
   endtask

   initial begin
      logic [23:0] d;
      logic [23:0] a0, a1, a2;
      reset_n      = 1'b0;
      sink_data    = '0;
      sink_valid   = 1'b0;
      sink_sop     = 1'b0;
      sink_eop     = 1'b0;
      source_ready = 1'b1;
      mode         = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", 32'(source_valid), 32'd0);
      check("reset_data", 32'(source_data), 32'd0);
      check("reset_sop_eop", 32'({source_sop, source_eop}), 32'd0);
      check("reset_sink_ready", 32'(sink_ready), 32'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Ramp as a short line ended by eop: both edges replicate
      test_ramp();

      // Full 2-line frame: impulse line, then a random line
      fe_count = 0;
      send_sop(24'h000000);
      exp_q.push_back({2'b00, 24'h000000});
      exp_q.push_back({2'b00, 24'h004000});
      exp_q.push_back({2'b00, 24'h008000});
      exp_q.push_back({2'b00, 24'h004000});
      exp_q.push_back({2'b00, 24'h000000});
      send_word(24'h000000, 1'b0, 1'b0);
      send_word(24'h000000, 1'b0, 1'b0);
      send_word(24'h00FF00, 1'b0, 1'b0);
      send_word(24'h000000, 1'b0, 1'b0);
      send_word(24'h000000, 1'b0, 1'b0);
      send_video_line(5, 1'b1);
      drain();
`ifdef STREAM_HBLUR_FRAMECHK_EN
      check("frame_err_good_frame", 32'(fe_count), 32'd0);
`endif

      // Bypass: mode low at SOP, raised mid-packet must not matter
      mode = 1'b0;
      send_sop(24'h000000);
      mode = 1'b1;
      for (int i = 0; i < 30; i++) begin
         d = 24'($urandom());
         exp_q.push_back({1'b0, i == 29, d});
         send_word(d, 1'b0, i == 29);
      end
      drain();

      // Stray word in IDLE dropped, then non-video packet forwarded verbatim
      send_word(24'hABCDEF, 1'b0, 1'b0);
      send_sop(24'h12345F);
      for (int i = 0; i < 9; i++) begin
         d = 24'($urandom());
         exp_q.push_back({1'b0, i == 8, d});
         send_word(d, 1'b0, i == 8);
      end
      drain();

      // Random backpressure on the ramp and a full frame
      rand_ready = 1'b1;
      test_ramp();
      send_sop(24'h000000);
      send_video_line(5, 1'b0);
      send_video_line(5, 1'b1);
      drain();
      rand_ready   = 1'b0;
      source_ready = 1'b1;

      // Short frame: eop after 6 pixels ends the second line after one pixel
      fe_count = 0;
      send_sop(24'h000000);
      send_video_line(5, 1'b0);
      send_video_line(1, 1'b1);
      drain();
`ifdef STREAM_HBLUR_FRAMECHK_EN
      check("frame_err_short_frame", 32'(fe_count), 32'd1);
`endif

      // SOP mid-line discards held pixels and starts over
      a0 = 24'($urandom());
      a1 = 24'($urandom());
      a2 = 24'($urandom());
      send_sop(24'h000000);
      exp_q.push_back({2'b00, mfilt(a0, a0, a1)});
      exp_q.push_back({2'b00, mfilt(a0, a1, a2)});
      send_word(a0, 1'b0, 1'b0);
      send_word(a1, 1'b0, 1'b0);
      send_word(a2, 1'b0, 1'b0);
      send_sop(24'h000000);
      send_video_line(5, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
